fdiv_seq: RTL and testbench

//   Sequential signed fixed-point divider; the inverse of the fixed-point multiply datapath.

---
 rtl/fdiv_seq.sv | 134 +++++++++++++
 tb/tb_fdiv_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - sequential signed fixed-point restoring divider, one quotient bit per clock
module fdiv_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_ovr,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovr,
    output logic             o_div_by_zero
);

    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [N-1:0]     POS_LIM = {{FRAC{1'b0}}, MAX_POS};
    localparam logic [N-1:0]     NEG_LIM = {{FRAC{1'b0}}, MAX_NEG};
    localparam logic [CW-1:0]    LAST    = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state;
    logic             sign_q;
    logic             ovr_q;
    logic [N-1:0]     num_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [N-2:0]     quo_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             fits;
    logic [N-1:0]     quo_next;
    logic             sat;
    logic [WIDTH-1:0] res_sat;

    // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is correct when read as unsigned
    assign abs_dvd = i_dividend[WIDTH-1] ? (~i_dividend + 1'b1) : i_dividend;
    assign abs_dvs = i_divisor[WIDTH-1]  ? (~i_divisor + 1'b1)  : i_divisor;

    // Borrow out of the trial subtraction tells whether the divisor fits
    assign rem_shift = {rem_q, num_q[N-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign fits      = ~rem_diff[WIDTH];
    assign quo_next  = {quo_q, fits};

    always_comb begin
        sat     = 1'b0;
        res_sat = '0;
        if (!sign_q) begin
            sat     = (quo_next > POS_LIM);
            res_sat = sat ? MAX_POS : quo_next[WIDTH-1:0];
        end else begin
            sat     = (quo_next > NEG_LIM);
            res_sat = sat ? MAX_NEG : (~quo_next[WIDTH-1:0] + 1'b1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            sign_q        <= 1'b0;
            ovr_q         <= 1'b0;
            num_q         <= '0;
            dvs_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            cnt_q         <= '0;
            o_busy        <= 1'b0;
            o_valid       <= 1'b0;
            o_result      <= '0;
            o_ovr         <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_valid <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        sign_q        <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                        ovr_q         <= i_ovr;
                        num_q         <= {abs_dvd, {FRAC{1'b0}}};
                        dvs_q         <= abs_dvs;
                        rem_q         <= '0;
                        quo_q         <= '0;
                        cnt_q         <= '0;
                        o_busy        <= 1'b1;
                        o_ovr         <= 1'b0;
                        o_div_by_zero <= 1'b0;
                        if (i_divisor == '0) begin
                            state         <= S_DONE;
                            o_result      <= i_dividend[WIDTH-1] ? MAX_NEG : MAX_POS;
                            o_ovr         <= 1'b1;
                            o_div_by_zero <= 1'b1;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    quo_q <= quo_next[N-2:0];
                    num_q <= {num_q[N-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state    <= S_DONE;
                        o_result <= res_sat;
                        o_ovr    <= ovr_q | sat;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// tb/tb_fdiv_seq.sv - scoreboard bench for fdiv_seq (WIDTH=16, FRAC=8)
module tb_fdiv_seq;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int N     = WIDTH + FRAC;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             ovr_in;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             ovr;
    logic             dbz;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             ovr;
        logic             dbz;
    } exp_t;

    exp_t scb[$];

    fdiv_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_dividend    (dvd),
        .i_divisor     (dvs),
        .i_ovr         (ovr_in),
        .o_busy        (busy),
        .o_valid       (valid),
        .o_result      (result),
        .o_ovr         (ovr),
        .o_div_by_zero (dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic fl);
        exp_t   e;
        longint sa, sd, ma, md, q;
        logic   neg, s;
        sa = longint'($signed(a));
        sd = longint'($signed(b));
        e.dbz = 1'b0;
        if (sd == 0) begin
            e.res = (sa >= 0) ? 16'h7FFF : 16'h8000;
            e.ovr = 1'b1;
            e.dbz = 1'b1;
            return e;
        end
        ma  = (sa < 0) ? -sa : sa;
        md  = (sd < 0) ? -sd : sd;
        q   = (ma * (longint'(1) << FRAC)) / md;
        neg = (sa < 0) != (sd < 0);
        s   = 1'b0;
        if (!neg) begin
            if (q > 32767) begin e.res = 16'h7FFF; s = 1'b1; end
            else e.res = 16'(q);
        end else begin
            if (q > 32768) begin e.res = 16'h8000; s = 1'b1; end
            else e.res = 16'(-q);
        end
        e.ovr = fl | s;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge where o_valid was seen (or the one after, if !b2b)
    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic fl, input int pulse_at, input bit b2b, output int vcyc);
        exp_t e;
        int   lat;
        bit   seen;
        dvd    = a;
        dvs    = b;
        ovr_in = fl;
        start  = 1'b1;
        scb.push_back(model(a, b, fl));
        @(posedge clk);
        #1;
        start  = 1'b0;
        dvd    = 16'($urandom);
        dvs    = 16'($urandom);
        ovr_in = 1'($urandom);
        lat    = 0;
        seen   = 1'b0;
        vcyc   = -1;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (valid === 1'b1) begin
                seen = 1'b1;
                vcyc = cyc;
            end else begin
                start = (lat == pulse_at);
            end
        end
        start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no o_valid within 100 cycles", name);
            void'(scb.pop_front());
            return;
        end
        checks++;
        if (lat !== ((b == 0) ? 1 : N + 1)) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, (b == 0) ? 1 : N + 1);
        end
        e = scb.pop_front();
        checks++;
        if (result !== e.res) begin
            errors++;
            $display("FAIL %s result got %h want %h", name, result, e.res);
        end
        checks++;
        if (ovr !== e.ovr) begin
            errors++;
            $display("FAIL %s ovr got %b want %b", name, ovr, e.ovr);
        end
        checks++;
        if (dbz !== e.dbz) begin
            errors++;
            $display("FAIL %s div_by_zero got %b want %b", name, dbz, e.dbz);
        end
        if (!b2b) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL %s valid_width got %b want 0", name, valid);
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        dvd    = '0;
        dvs    = '0;
        ovr_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, valid, result, ovr, dbz} !== '0) begin
            errors++;
            $display("FAIL reset outputs got %b_%b_%h_%b_%b want all 0", busy, valid, result, ovr, dbz);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset idle busy/valid got %b%b want 00", busy, valid);
        end
    endtask

    task automatic test_basic();
        int v;
        run_op("basic_1.5/0.5", 16'h0180, 16'h0080, 1'b0, -1, 1'b0, v);
        checks++;
        if (16'h0300 !== model(16'h0180, 16'h0080, 1'b0).res) begin
            errors++;
            $display("FAIL basic_model got %h want 0300", model(16'h0180, 16'h0080, 1'b0).res);
        end
    endtask

    task automatic test_signs();
        int v;
        run_op("neg3/2",   16'hFD00, 16'h0200, 1'b0, -1, 1'b0, v);
        run_op("1/3",      16'h0100, 16'h0300, 1'b0, -1, 1'b0, v);
        run_op("neg1/3",   16'hFF00, 16'h0300, 1'b0, -1, 1'b0, v);
        run_op("0/neg1",   16'h0000, 16'hFF00, 1'b0, -1, 1'b0, v);
        run_op("neg1/neg3", 16'hFF00, 16'hFD00, 1'b0, -1, 1'b0, v);
    endtask

    task automatic test_saturation();
        int v;
        run_op("sat_100/0.25",  16'h6400, 16'h0040, 1'b0, -1, 1'b0, v);
        run_op("sat_neg128/neg1", 16'h8000, 16'hFF00, 1'b0, -1, 1'b0, v);
        run_op("edge_neg128/1", 16'h8000, 16'h0100, 1'b0, -1, 1'b0, v);
        run_op("sat_neg100/0.25", 16'h9C00, 16'h0040, 1'b0, -1, 1'b0, v);
    endtask

    task automatic test_div_by_zero();
        int v;
        run_op("dbz_neg", 16'hFF00, 16'h0000, 1'b0, -1, 1'b0, v);
        run_op("dbz_zero", 16'h0000, 16'h0000, 1'b0, -1, 1'b0, v);
    endtask

    task automatic test_ovr_flag();
        int v;
        run_op("ovr_in_set",   16'h0100, 16'h0100, 1'b1, -1, 1'b0, v);
        run_op("ovr_in_clear", 16'h0100, 16'h0100, 1'b0, -1, 1'b0, v);
    endtask

    task automatic test_ignored_start();
        int v;
        int extra;
        run_op("ign_calc", 16'h0180, 16'h0080, 1'b0, 10, 1'b0, v);
        run_op("ign_done", 16'h0100, 16'h0300, 1'b0, N, 1'b0, v);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignored_start extra_valids got %0d want 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        int extra;
        int v;
        dvd    = 16'h0180;
        dvs    = 16'h0080;
        ovr_in = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL mid_reset valids got %0d want 0", extra);
        end
        checks++;
        if ({busy, valid, result, ovr, dbz} !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs got %b_%b_%h_%b_%b want all 0", busy, valid, result, ovr, dbz);
        end
        run_op("after_reset", 16'hFF00, 16'h0300, 1'b0, -1, 1'b0, v);
    endtask

    task automatic test_back_to_back();
        int v1, v2, v3;
        run_op("b2b_a", 16'h0180, 16'h0080, 1'b0, -1, 1'b1, v1);
        run_op("b2b_b", 16'h8000, 16'hFF00, 1'b0, -1, 1'b1, v2);
        run_op("b2b_c", 16'h7FFF, 16'h0001, 1'b1, -1, 1'b0, v3);
        checks++;
        if ((v2 - v1) !== N + 2) begin
            errors++;
            $display("FAIL b2b_period got %0d want %0d", v2 - v1, N + 2);
        end
    endtask

    task automatic test_random();
        int v;
        logic [WIDTH-1:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            b = (i % 4 == 3) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            run_op($sformatf("rand_%0d", i), a, b, 1'($urandom), -1, 1'b0, v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_div_by_zero();
        test_ovr_flag();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        checks++;
        if (scb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", scb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
